// File: rtl/id_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_pipe_ctrl
// Purpose  : IF->ID buffer (skid or single entry) with load-use interlock
//            and a saturating stall counter.
// Revision : 1.0
// ============================================================================
module id_pipe_ctrl #(
    parameter int XLEN  = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_inst,
    input  logic             exe_valid,
    input  logic             exe_mem_re,
    input  logic [4:0]       exe_rd,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam bit               c_HAS_SKID = (SKID != 0);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    // Entry 0 is the head; entry 1 only ever fills when a skid slot exists.
    logic             r_v0, r_v1;
    logic [XLEN-1:0]  r_pc0, r_pc1;
    logic [31:0]      r_inst0, r_inst1;
    logic [CNT_W-1:0] r_cnt;

    logic       w_acc, w_con;
    logic       w_v0_nxt, w_v1_nxt;
    logic       w_ld0_in, w_ld0_e1, w_ld1_in;
    logic [6:0] w_op;
    logic [4:0] w_rs1, w_rs2;
    logic       w_rs1_used, w_rs2_used, w_hazard;

    always_comb begin
        w_op       = r_inst0[6:0];
        w_rs1      = r_inst0[19:15];
        w_rs2      = r_inst0[24:20];
        w_rs1_used = !((w_op == 7'b0110111) || (w_op == 7'b0010111) || (w_op == 7'b1101111));
        w_rs2_used =  (w_op == 7'b0110011) || (w_op == 7'b0100011) || (w_op == 7'b1100011);
        w_hazard   = r_v0 & exe_valid & exe_mem_re & (exe_rd != 5'd0) &
                     ((w_rs1_used & (w_rs1 == exe_rd)) | (w_rs2_used & (w_rs2 == exe_rd)));
    end

    assign hazard    = w_hazard;
    assign out_valid = r_v0 & ~w_hazard;
    assign out_pc    = r_pc0;
    assign out_inst  = r_inst0;
    assign stall_cnt = r_cnt;

    assign w_acc = in_valid & in_ready & ~flush;
    assign w_con = out_valid & out_ready & ~flush;

    always_comb begin
        w_v0_nxt = r_v0;
        w_v1_nxt = r_v1;
        w_ld0_in = 1'b0;
        w_ld0_e1 = 1'b0;
        w_ld1_in = 1'b0;
        if (flush) begin
            w_v0_nxt = 1'b0;
            w_v1_nxt = 1'b0;
        end else begin
            case ({w_acc, w_con})
                2'b10: begin
                    if (!r_v0) begin
                        w_ld0_in = 1'b1;
                        w_v0_nxt = 1'b1;
                    end else begin
                        w_ld1_in = 1'b1;
                        w_v1_nxt = 1'b1;
                    end
                end
                2'b01: begin
                    w_ld0_e1 = r_v1;
                    w_v0_nxt = r_v1;
                    w_v1_nxt = 1'b0;
                end
                2'b11: begin
                    // Order is kept: the new beat goes to the head only if nothing waits behind it.
                    if (r_v1) begin
                        w_ld0_e1 = 1'b1;
                        w_ld1_in = 1'b1;
                    end else begin
                        w_ld0_in = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        w_v1_nxt = w_v1_nxt & c_HAS_SKID;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_pc0   <= '0;
            r_pc1   <= '0;
            r_inst0 <= '0;
            r_inst1 <= '0;
            r_cnt   <= '0;
        end else begin
            r_v0 <= w_v0_nxt;
            r_v1 <= w_v1_nxt;
            if (w_ld0_in) begin
                r_pc0   <= in_pc;
                r_inst0 <= in_inst;
            end else if (w_ld0_e1) begin
                r_pc0   <= r_pc1;
                r_inst0 <= r_inst1;
            end
            if (w_ld1_in) begin
                r_pc1   <= in_pc;
                r_inst1 <= in_inst;
            end
            if (w_hazard && (r_cnt != c_CNT_MAX))
                r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    generate
        if (c_HAS_SKID) begin : g_skid
            // Registered ready breaks the out_ready -> in_ready path.
            logic r_rdy;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_rdy <= 1'b0;
                else
                    r_rdy <= ~w_v1_nxt;
            end
            assign in_ready = r_rdy;
        end else begin : g_single
            assign in_ready = ~r_v0 | (out_valid & out_ready);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_id_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_pipe_ctrl
// Purpose  : Drives a skid instance (A) and a single-entry, 2-bit-counter
//            instance (B) from shared stimulus against a queue-level model.
// Revision : 1.0
// ============================================================================
module tb_id_pipe_ctrl;

    localparam logic [31:0] c_NOP = 32'h0000_0013;
    localparam logic [31:0] c_ADD = 32'h0020_8033;
    localparam logic [31:0] c_LUI = 32'h0000_20B7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        exe_valid = 1'b0;
    logic        exe_mem_re = 1'b0;
    logic [4:0]  exe_rd = 5'd0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_inst = 32'd0;

    logic        in_ready_a, out_valid_a, hazard_a;
    logic [31:0] out_pc_a, out_inst_a;
    logic [15:0] stall_a;
    logic        in_ready_b, out_valid_b, hazard_b;
    logic [31:0] out_pc_b, out_inst_b;
    logic [1:0]  stall_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_pipe_ctrl #(.XLEN(32), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a), .out_inst(out_inst_a),
        .exe_valid(exe_valid), .exe_mem_re(exe_mem_re), .exe_rd(exe_rd),
        .hazard(hazard_a), .stall_cnt(stall_a)
    );

    id_pipe_ctrl #(.XLEN(32), .SKID(0), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_inst(out_inst_b),
        .exe_valid(exe_valid), .exe_mem_re(exe_mem_re), .exe_rd(exe_rd),
        .hazard(hazard_b), .stall_cnt(stall_b)
    );

    // Reference model: per instance an ordered queue of held beats (index 0 = oldest).
    logic [31:0] m_pc   [2][2];
    logic [31:0] m_inst [2][2];
    int          m_occ  [2];
    int          m_cnt  [2];
    bit          m_rdy_a;

    function automatic int cap(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int cmax(input int d);
        return (d == 0) ? 65535 : 3;
    endfunction

    function automatic bit reads_rs1(input logic [31:0] inst);
        return !(inst[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    endfunction

    function automatic bit reads_rs2(input logic [31:0] inst);
        return inst[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit m_haz(input int d);
        logic [31:0] h;
        if (m_occ[d] == 0 || !exe_valid || !exe_mem_re || exe_rd == 5'd0) return 1'b0;
        h = m_inst[d][0];
        return (reads_rs1(h) && h[19:15] == exe_rd) || (reads_rs2(h) && h[24:20] == exe_rd);
    endfunction

    function automatic bit m_ov(input int d);
        return (m_occ[d] > 0) && !m_haz(d);
    endfunction

    function automatic bit m_rdy(input int d);
        if (d == 0) return m_rdy_a;
        return (m_occ[1] == 0) || (m_ov(1) && out_ready);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_occ[d] = 0;
            m_cnt[d] = 0;
        end
        m_rdy_a = 1'b0;
    endtask

    // Applies one rising edge to the model using the inputs held during the cycle.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit haz, ov, rdy;
            haz = m_haz(d);
            ov  = m_ov(d);
            rdy = m_rdy(d);
            if (haz && m_cnt[d] < cmax(d)) m_cnt[d]++;
            if (flush) begin
                m_occ[d] = 0;
            end else begin
                if (ov && out_ready) begin
                    m_pc[d][0]   = m_pc[d][1];
                    m_inst[d][0] = m_inst[d][1];
                    m_occ[d]--;
                end
                if (in_valid && rdy) begin
                    if (m_occ[d] >= cap(d)) $display("FAIL model_overflow: got %0d expected <%0d", m_occ[d], cap(d));
                    else begin
                        m_pc[d][m_occ[d]]   = in_pc;
                        m_inst[d][m_occ[d]] = in_inst;
                        m_occ[d]++;
                    end
                end
            end
        end
        m_rdy_a = (m_occ[0] < 2);
    endtask

    task automatic drive(input bit iv, input logic [31:0] pc, input logic [31:0] inst,
                         input bit ordy, input bit fl, input bit ev, input bit er,
                         input logic [4:0] rd);
        @(posedge clk);
        #1;
        if (rst_n) model_edge();
        in_valid   = iv;
        in_pc      = pc;
        in_inst    = inst;
        out_ready  = ordy;
        flush      = fl;
        exe_valid  = ev;
        exe_mem_re = er;
        exe_rd     = rd;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 32'd0, c_NOP, ordy, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; exe_valid = 1'b0; exe_mem_re = 1'b0;
        rst_n = 1'b0;
        model_clear();
        #3;
        check("rst.out_valid_a", 64'(out_valid_a), 64'd0);
        check("rst.out_pc_a",    64'(out_pc_a),    64'd0);
        check("rst.out_inst_a",  64'(out_inst_a),  64'd0);
        check("rst.stall_a",     64'(stall_a),     64'd0);
        check("rst.out_valid_b", 64'(out_valid_b), 64'd0);
        check("rst.stall_b",     64'(stall_b),     64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [8] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111,
                                 7'b0010111, 7'b1101111, 7'b0000011, 7'b0010011};
        logic [31:0] r;
        r        = $urandom;
        r[6:0]   = ops[$urandom_range(0, 7)];
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    // Monitor: compares every DUT output against the model head each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("a.in_ready",  64'(in_ready_a),  64'(m_rdy(0)));
            check("a.out_valid", 64'(out_valid_a), 64'(m_ov(0)));
            check("a.hazard",    64'(hazard_a),    64'(m_haz(0)));
            check("a.stall_cnt", 64'(stall_a),     64'(m_cnt[0]));
            check("b.in_ready",  64'(in_ready_b),  64'(m_rdy(1)));
            check("b.out_valid", 64'(out_valid_b), 64'(m_ov(1)));
            check("b.hazard",    64'(hazard_b),    64'(m_haz(1)));
            check("b.stall_cnt", 64'(stall_b),     64'(m_cnt[1]));
            if (out_valid_a && m_occ[0] > 0) begin
                check("a.out_pc",   64'(out_pc_a),   64'(m_pc[0][0]));
                check("a.out_inst", 64'(out_inst_a), 64'(m_inst[0][0]));
            end
            if (out_valid_b && m_occ[1] > 0) begin
                check("b.out_pc",   64'(out_pc_b),   64'(m_pc[1][0]));
                check("b.out_inst", 64'(out_inst_b), 64'(m_inst[1][0]));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pc_ctr;
        model_clear();

        do_reset();
        idle(1'b0);
        @(negedge clk);
        check("rst.in_ready_a", 64'(in_ready_a), 64'd1);
        check("rst.in_ready_b", 64'(in_ready_b), 64'd1);

        // Skid fill with downstream stalled.
        drive(1'b1, 32'h100, c_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 32'h104, c_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 32'h108, c_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        @(negedge clk);
        check("fill.in_ready_a", 64'(in_ready_a), 64'd0);
        check("fill.out_pc_a",   64'(out_pc_a),   64'h100);
        repeat (3) idle(1'b1);
        @(negedge clk);
        check("fill.drained_a", 64'(out_valid_a), 64'd0);

        // Load-use interlock on rs2 for three cycles.
        do_reset();
        drive(1'b1, 32'h300, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, c_NOP, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
            @(negedge clk);
            check("lu.hazard_a",    64'(hazard_a),    64'd1);
            check("lu.out_valid_a", 64'(out_valid_a), 64'd0);
        end
        idle(1'b0);
        @(negedge clk);
        check("lu.stall_a",     64'(stall_a),     64'd3);
        check("lu.out_valid_a", 64'(out_valid_a), 64'd1);

        // LUI reads no source registers.
        do_reset();
        drive(1'b1, 32'h400, c_LUI, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 32'd0, c_NOP, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1);
        @(negedge clk);
        check("lui.hazard_rd1", 64'(hazard_a), 64'd0);
        drive(1'b0, 32'd0, c_NOP, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        @(negedge clk);
        check("lui.hazard_rd0",    64'(hazard_a),    64'd0);
        check("lui.out_valid_a",   64'(out_valid_a), 64'd1);

        // Flush with a full buffer and a beat on the input.
        do_reset();
        drive(1'b1, 32'h500, c_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 32'h504, c_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 32'h508, c_NOP, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        @(negedge clk);
        check("flush.out_valid_a", 64'(out_valid_a), 64'd0);
        check("flush.in_ready_a",  64'(in_ready_a),  64'd1);
        check("flush.out_valid_b", 64'(out_valid_b), 64'd0);
        drive(1'b1, 32'h600, c_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        @(negedge clk);
        check("flush.empty_drop_a", 64'(out_valid_a), 64'd0);
        drive(1'b1, 32'h700, c_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        @(negedge clk);
        check("flush.next_pc_a", 64'(out_pc_a), 64'h700);

        // Counter saturation on B, then flush during hazard.
        do_reset();
        drive(1'b1, 32'h800, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i <= 6; i++) begin
            drive(1'b0, 32'd0, c_NOP, 1'b0, 1'b0, (i < 6), (i < 6), 5'd2);
            @(negedge clk);
            if (i > 0) check("sat.stall_b", 64'(stall_b), 64'((i < 3) ? i : 3));
        end
        drive(1'b0, 32'd0, c_NOP, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2);
        idle(1'b0);
        @(negedge clk);
        check("flhaz.stall_a",     64'(stall_a),     64'd7);
        check("flhaz.out_valid_a", 64'(out_valid_a), 64'd0);

        // Single-entry streaming, no bubbles.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'(4 * k), c_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
            if (k > 0) begin
                check("stream.out_valid_b", 64'(out_valid_b), 64'd1);
                check("stream.out_pc_b",    64'(out_pc_b),    64'(4 * (k - 1)));
                check("stream.in_ready_b",  64'(in_ready_b),  64'd1);
            end
        end

        // Randomised traffic.
        do_reset();
        pc_ctr = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 9) < 7), pc_ctr, rand_inst(),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)));
            pc_ctr = pc_ctr + 32'd4;
        end

        // Reset while beats are held.
        drive(1'b1, 32'h900, c_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 32'h904, c_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            @(negedge clk);
            check("midrst.out_valid_a", 64'(out_valid_a), 64'd0);
            check("midrst.out_valid_b", 64'(out_valid_b), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_pipe_ctrl.md
ID_PIPE_CTRL -- requirements
Module: id_pipe_ctrl

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning PC width in bits.
REQ-002 The module SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer, 0 = single-entry register.
REQ-003 The module SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  discard all held instructions (branch/jump redirect).
REQ-007 in_valid  input  1  IF beat valid.
REQ-008 in_ready  output  1  stage can accept an IF beat.
REQ-009 in_pc  input  XLEN  IF program counter.
REQ-010 in_inst  input  32  IF instruction word.
REQ-011 out_valid  output  1  head instruction valid and hazard-free, offered to decoder.
REQ-012 out_ready  input  1  downstream accepts head.
REQ-013 out_pc  output  XLEN  head PC.
REQ-014 out_inst  output  32  head instruction.
REQ-015 exe_valid  input  1  EXE stage holds a valid instruction.
REQ-016 exe_mem_re  input  1  EXE instruction is a load.
REQ-017 exe_rd  input  5  EXE destination register.
REQ-018 hazard  output  1  load-use interlock active this cycle.
REQ-019 stall_cnt  output  CNT_W  count of hazard-stall cycles.

Function
REQ-020 Storage SHALL be an in-order buffer of depth 2 (SKID=1) or 1 (SKID=0); entries hold {pc, inst, valid}.
REQ-021 A beat SHALL be accepted on a rising edge when in_valid & in_ready & ~flush.
REQ-022 A head SHALL be consumed on a rising edge when out_valid & out_ready & ~flush.
REQ-023 SKID=1: in_ready SHALL be a registered signal equal to ~(second entry valid); no combinational path from out_ready to in_ready.
REQ-024 SKID=0: in_ready SHALL be ~head_valid | (out_valid & out_ready).
REQ-025 Simultaneous accept and consume SHALL keep occupancy unchanged and preserve order; the new beat becomes head only when the buffer becomes empty.
REQ-026 Accept with buffer full SHALL be impossible (in_ready=0); consume with buffer empty SHALL be impossible (out_valid=0).
REQ-027 out_pc/out_inst SHALL show the head entry; value SHALL be don't-care when head invalid but SHALL be zero after reset.
REQ-028 rs1 SHALL be inst[19:15], used unless opcode inst[6:0] is 0110111, 0010111 or 1101111.
REQ-029 rs2 SHALL be inst[24:20], used only for opcodes 0110011, 0100011, 1100011.
REQ-030 hazard SHALL be head_valid & exe_valid & exe_mem_re & (exe_rd != 0) & ((rs1 used & rs1==exe_rd) | (rs2 used & rs2==exe_rd)), combinational.
REQ-031 out_valid SHALL be head_valid & ~hazard; while hazard, head SHALL be held unchanged and accepts SHALL continue while space remains.
REQ-032 stall_cnt SHALL increment by 1 each cycle hazard=1, saturating at 2^CNT_W-1; not cleared by flush.
REQ-033 flush SHALL invalidate all entries on the next edge; the concurrent in beat SHALL be dropped; out_valid SHALL be 0 in the cycle after flush.
REQ-034 flush with hazard in the same cycle SHALL still count the stall cycle and still clear the buffer.

Reset
REQ-035 rst_n low SHALL asynchronously clear all entries, pc/inst to 0, stall_cnt to 0, out_valid to 0; in_ready SHALL be 1 from the first edge after release.
REQ-036 Reset asserted mid-transfer SHALL drop all held beats; no beat SHALL appear at out after release until a new accept.

Verification
REQ-037 SKID=1, out_ready=0, push pc 0x100,0x104,0x108 -> first two accepted, in_ready=0 after second, third stalled; out_pc=0x100.
REQ-038 Head inst 0x00208033 (add x0,x1,x2), exe_valid=1, exe_mem_re=1, exe_rd=2 for 3 cycles -> hazard=1, out_valid=0 for 3 cycles, stall_cnt=3, then out_valid=1.
REQ-039 Head inst 0x000020B7 (lui x1), exe_rd=0 or exe_rd=1 load -> hazard=0 (rs1/rs2 unused or x0).
REQ-040 Buffer holding 2 beats, flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy 0, incoming beat absent.
REQ-041 CNT_W=2, hazard held 6 cycles -> stall_cnt 1,2,3,3,3,3.
REQ-042 SKID=0, continuous in_valid and out_ready=1 -> one beat per cycle, order 0x0,0x4,0x8 preserved, no bubbles.
